dlt_q_signature: RTL and testbench

- Capture/compression stage directly downstream of a CC_DLT latch-bank test top.
- Synchronises the asynchronous latch outputs q[WIDTH-1:0] into the clock domain and waits a settle interval.
- Compresses SAMPLES consecutive samples into a 32-bit MISR signature, so on-board checking compares one word against a golden value.
- Start/done handshake lets a test controller re-arm it per latch configuration.

---
 rtl/dlt_q_signature.sv | 190 +++++++++++++++++++
 tb/tb_dlt_q_signature.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlt_q_signature.sv
// -----------------------------------------------------------------------------
// dlt_q_signature
//
// Capture/compression stage placed behind a CC_DLT latch-bank test top. The
// raw latch outputs are brought into the clk domain through a two-flop
// synchroniser. After a start request the block waits SETTLE cycles, then
// folds SAMPLES consecutive synchronised samples down to 32 bits and absorbs
// them into a MISR. The resulting signature can be compared against a single
// golden word.
//
// Ports:
//   clk        in   single clock, all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   q_in       in   [WIDTH-1:0] raw latch outputs, asynchronous to clk
//   start      in   run request (pulse or level), accepted in IDLE/DONE only
//   busy       out  high while settling or capturing
//   done       out  high in DONE, signature valid and held
//   signature  out  [31:0] MISR result
//   change_cnt out  [15:0] sample-to-sample change count (optional feature)
//
// Optional feature macro: DLT_Q_SIGNATURE_CHANGE_CNT_EN
//   defined   : change_cnt counts CAPTURE steps (from the second one on)
//               where the sample differs from the previous one, saturating.
//   undefined : no prev register or comparator; change_cnt is tied to zero.
// -----------------------------------------------------------------------------
module dlt_q_signature #(
    parameter int          WIDTH   = 44,
    parameter int          SAMPLES = 16,
    parameter int          SETTLE  = 4,
    parameter logic [31:0] POLY    = 32'h04C11DB7,
    parameter logic [31:0] SEED    = 32'hFFFFFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] q_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [31:0]      signature,
    output logic [15:0]      change_cnt
);

    localparam int          CHUNKS      = (WIDTH + 31) / 32;
    localparam logic [15:0] LAST_SAMPLE = 16'(SAMPLES - 1);
    localparam logic [7:0]  LAST_SETTLE = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0]      r_q_s1;
    logic [WIDTH-1:0]      r_qs;
    logic [7:0]            r_settle_cnt;
    logic [15:0]           r_sample_cnt;
    logic [31:0]           r_signature;

    logic                  w_accept;
    logic                  w_last_settle;
    logic                  w_last_sample;
    logic [CHUNKS*32-1:0]  w_padded;
    logic [31:0]           w_folded;
    logic [31:0]           w_misr_next;

    // -------------------------------------------------------------------------
    // Two-flop synchroniser; only the second stage feeds the datapath.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_s1 <= '0;
            r_qs   <= '0;
        end else begin
            r_q_s1 <= q_in;
            r_qs   <= r_q_s1;
        end
    end

    // -------------------------------------------------------------------------
    // Fold WIDTH bits to 32 by XORing 32-bit chunks; the top chunk is
    // zero-padded at its MSB end.
    // -------------------------------------------------------------------------
    always_comb begin
        w_padded             = '0;
        w_padded[WIDTH-1:0]  = r_qs;
        w_folded             = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            w_folded = w_folded ^ w_padded[i*32 +: 32];
        end
    end

    // Shift left, feed back POLY when the outgoing MSB is set, absorb sample.
    assign w_misr_next = {r_signature[30:0], 1'b0}
                       ^ (r_signature[31] ? POLY : 32'h0)
                       ^ w_folded;

    assign w_accept      = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
    assign w_last_settle = (r_settle_cnt == LAST_SETTLE);
    assign w_last_sample = (r_sample_cnt == LAST_SAMPLE);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // With no settle interval the first sample is taken on
                    // the very next edge.
                    w_state_next = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_last_settle) begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_last_sample) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Counters and signature
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_signature  <= '0;
        end else if (w_accept) begin
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_signature  <= SEED;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + 8'd1;
        end else if (r_state == ST_CAPTURE) begin
            r_sample_cnt <= r_sample_cnt + 16'd1;
            r_signature  <= w_misr_next;
        end
    end

`ifdef DLT_Q_SIGNATURE_CHANGE_CNT_EN
    logic [WIDTH-1:0] r_prev;
    logic [15:0]      r_change_cnt;

    // r_sample_cnt is still zero on the first CAPTURE step, so the first
    // sample only primes r_prev and is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev       <= '0;
            r_change_cnt <= '0;
        end else if (w_accept) begin
            r_change_cnt <= '0;
        end else if (r_state == ST_CAPTURE) begin
            r_prev <= r_qs;
            if ((r_sample_cnt != 16'd0) && (r_qs != r_prev)
                    && (r_change_cnt != 16'hFFFF)) begin
                r_change_cnt <= r_change_cnt + 16'd1;
            end
        end
    end

    assign change_cnt = r_change_cnt;
`else
    assign change_cnt = 16'h0000;
`endif

    assign busy      = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
    assign done      = (r_state == ST_DONE);
    assign signature = r_signature;

endmodule

// File: tb/tb_dlt_q_signature.sv
module tb_dlt_q_signature;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk;
    logic        rst_n;
    logic [43:0] q_in;
    logic        start_a;
    logic        start_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [31:0] sig_a, sig_b;
    logic [15:0] chg_a, chg_b;

    int checks;
    int failures;

    // Default configuration: SETTLE=4, SAMPLES=16
    dlt_q_signature u_dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_in       (q_in),
        .start      (start_a),
        .busy       (busy_a),
        .done       (done_a),
        .signature  (sig_a),
        .change_cnt (chg_a)
    );

    // Minimal configuration: SETTLE=0, SAMPLES=1
    dlt_q_signature #(
        .SETTLE  (0),
        .SAMPLES (1)
    ) u_dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_in       (q_in),
        .start      (start_b),
        .busy       (busy_b),
        .done       (done_b),
        .signature  (sig_b),
        .change_cnt (chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference MISR over n identical samples of q.
    function automatic logic [31:0] misr_const(input logic [43:0] q, input int n);
        logic [31:0] s;
        logic [31:0] f;
        s = SEED;
        f = q[31:0] ^ {20'b0, q[43:32]};
        for (int i = 0; i < n; i++) begin
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
        end
        return s;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || sig_a !== 32'h0 || chg_a !== 16'h0) begin
            failures++;
            $display("FAIL reset_a: busy=%b done=%b sig=%h chg=%h, required 0 0 00000000 0000",
                     busy_a, done_a, sig_a, chg_a);
        end
        checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0 || sig_b !== 32'h0) begin
            failures++;
            $display("FAIL reset_b: busy=%b done=%b sig=%h, required 0 0 00000000",
                     busy_b, done_b, sig_b);
        end
        $display("reset: busy_a=%b done_a=%b sig_a=%h", busy_a, done_a, sig_a);
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic run_single(input logic [43:0] q, input logic [31:0] exp_sig, input string name);
        q_in = q;
        repeat (3) tick();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checks++;
        if (busy_b !== 1'b1 || done_b !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: busy=%b done=%b, required 1 0", name, busy_b, done_b);
        end
        tick();
        checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || sig_b !== exp_sig) begin
            failures++;
            $display("FAIL %s_done: done=%b busy=%b sig=%h, required 1 0 %h",
                     name, done_b, busy_b, sig_b, exp_sig);
        end
        checks++;
        if (chg_b !== 16'h0) begin
            failures++;
            $display("FAIL %s_chg: chg=%h, required 0000", name, chg_b);
        end
        $display("%s: q=%h sig=%h done=%b", name, q, sig_b, done_b);
    endtask

    task automatic test_single_sample();
        run_single(44'h0, 32'hFB3EE249, "single_zero");
        run_single(44'hFFFFFFFFFFF, 32'h04C11249, "single_ones");
    endtask

    task automatic test_default_timing();
        logic [43:0] q;
        logic [31:0] held;
        q = 44'h123456789AB;
        q_in = q;
        repeat (3) tick();
        start_a = 1'b1;
        tick();                       // edge E0
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            failures++;
            $display("FAIL timing_e0: busy=%b done=%b, required 1 0", busy_a, done_a);
        end
        for (int i = 1; i <= 20; i++) begin
            if (i == 6) start_a = 1'b1;   // sampled at E0+6, must be ignored
            tick();
            start_a = 1'b0;
            checks++;
            if (i < 20) begin
                if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                    failures++;
                    $display("FAIL timing_e%0d: busy=%b done=%b, required 1 0", i, busy_a, done_a);
                end
            end else begin
                if (busy_a !== 1'b0 || done_a !== 1'b1) begin
                    failures++;
                    $display("FAIL timing_e%0d: busy=%b done=%b, required 0 1", i, busy_a, done_a);
                end
            end
        end
        checks++;
        if (sig_a !== misr_const(q, 16)) begin
            failures++;
            $display("FAIL timing_sig: sig=%h, required %h", sig_a, misr_const(q, 16));
        end
        held = sig_a;
        q_in = 44'h0F0F0F0F0F0;
        repeat (4) tick();
        checks++;
        if (done_a !== 1'b1 || sig_a !== misr_const(q, 16)) begin
            failures++;
            $display("FAIL timing_hold: done=%b sig=%h, required 1 %h", done_a, sig_a, misr_const(q, 16));
        end
        $display("default_timing: sig=%h held=%h done=%b", sig_a, held, done_a);
    endtask

    task automatic test_reset_abort();
        logic [43:0] q;
        int waited;
        q = 44'hABC0123DEF4;
        q_in = q;
        repeat (3) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        #2 rst_n = 1'b0;              // mid-run, away from any edge
        #1;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0 || sig_a !== 32'h0) begin
            failures++;
            $display("FAIL abort_reset: done=%b busy=%b sig=%h, required 0 0 00000000",
                     done_a, busy_a, sig_a);
        end
        #3 rst_n = 1'b1;
        repeat (3) tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        waited = 0;
        while (!done_a && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (waited != 20) begin
            failures++;
            $display("FAIL abort_latency: edges=%0d, required 20", waited);
        end
        checks++;
        if (sig_a !== misr_const(q, 16)) begin
            failures++;
            $display("FAIL abort_sig: sig=%h, required %h", sig_a, misr_const(q, 16));
        end
        $display("reset_abort: rerun sig=%h after %0d edges", sig_a, waited);
    endtask

    task automatic test_change_cnt();
        logic [15:0] exp_toggle;
        logic [31:0] held;
        int waited;
`ifdef DLT_Q_SIGNATURE_CHANGE_CNT_EN
        exp_toggle = 16'd15;
`else
        exp_toggle = 16'd0;
`endif
        // The previous run used a constant q_in.
        checks++;
        if (chg_a !== 16'h0) begin
            failures++;
            $display("FAIL chg_const: chg=%h, required 0000", chg_a);
        end
        q_in = 44'h0;
        tick();
        start_a = 1'b1;
        q_in = ~q_in;
        tick();
        start_a = 1'b0;
        waited = 0;
        while (!done_a && waited < 40) begin
            q_in = ~q_in;
            tick();
            waited++;
        end
        checks++;
        if (!done_a) begin
            failures++;
            $display("FAIL chg_timeout: done=%b, required 1", done_a);
        end
        checks++;
        if (chg_a !== exp_toggle) begin
            failures++;
            $display("FAIL chg_toggle: chg=%0d, required %0d", chg_a, exp_toggle);
        end
        held = sig_a;
        for (int i = 0; i < 3; i++) begin
            q_in = ~q_in;
            tick();
        end
        checks++;
        if (sig_a !== held || chg_a !== exp_toggle) begin
            failures++;
            $display("FAIL chg_hold: sig=%h chg=%0d, required %h %0d", sig_a, chg_a, held, exp_toggle);
        end
        $display("change_cnt: toggle chg=%0d sig=%h", chg_a, sig_a);
    endtask

    task automatic test_back_to_back();
        logic [43:0] q;
        logic        prev_done;
        int          pulses;
        q = 44'hABCDE012345;
        q_in = q;
        repeat (3) tick();
        start_a = 1'b1;
        prev_done = done_a;
        pulses = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (done_a !== 1'b0 || busy_a !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_accept: done=%b busy=%b, required 0 1", done_a, busy_a);
                end
            end
            if (done_a === 1'b1) begin
                pulses++;
                checks++;
                if (prev_done === 1'b1) begin
                    failures++;
                    $display("FAIL b2b_width: done high two cycles at step %0d, required one", i);
                end
                checks++;
                if (sig_a !== misr_const(q, 16)) begin
                    failures++;
                    $display("FAIL b2b_sig: sig=%h, required %h", sig_a, misr_const(q, 16));
                end
                $display("back_to_back: pulse %0d at step %0d sig=%h", pulses, i, sig_a);
            end
            prev_done = done_a;
        end
        start_a = 1'b0;
        // Runs take 21 edges each when start is held, so 70 edges yield 3.
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL b2b_count: pulses=%0d, required 3", pulses);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        q_in     = '0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        test_reset();
        test_single_sample();
        test_default_timing();
        test_reset_abort();
        test_change_cnt();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
